dmem_access_ctrl: RTL and testbench
===================================

DMEM_ACCESS_CTRL -- requirements
Module: dmem_access_ctrl

Interface
REQ-001 Parameter ADDR_W, default 32, byte-address width.
REQ-002 Parameter DATA_W, default 32, data width; only 32 is supported.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 req_valid  in  1  access request present.
REQ-006 req_ready  out  1  controller accepts a request this cycle.
REQ-007 req_we  in  1  1 = store, 0 = load.
REQ-008 req_type  in  3  000 byte signed, 001 half signed, 01x word, 100 byte unsigned, 101 half unsigned.
REQ-009 req_addr  in  ADDR_W  byte address.
REQ-010 req_wdata  in  DATA_W  store data, right-aligned.
REQ-011 resp_valid  out  1  one-cycle completion pulse.
REQ-012 resp_rdata  out  DATA_W  extended load data; 0 for stores and errors.
REQ-013 resp_err  out  1  misaligned access, qualified by resp_valid.
REQ-014 ram_en  out  1  RAM access strobe.
REQ-015 ram_we  out  1  RAM write enable, qualified by ram_en.
REQ-016 ram_addr  out  ADDR_W-2  word address (req_addr[ADDR_W-1:2]).
REQ-017 ram_wdata  out  DATA_W  full-word write data.
REQ-018 ram_rdata  in  DATA_W  read data, valid the cycle after a read strobe.
REQ-019 busy  out  1  state != IDLE.

Function
REQ-020 Handshake: a request is accepted when req_valid & req_ready; req_ready = 1 only in IDLE.
REQ-021 On accept, we, type, addr and wdata are captured into registers; later input changes have no effect.
REQ-022 FSM states: IDLE, RD, FIN, WR, ERR.
REQ-023 IDLE->ERR on accept when misaligned (half with addr[0]=1; word with addr[1:0]!=0).
REQ-024 IDLE->WR on accept of an aligned word store.
REQ-025 IDLE->RD on accept of any other aligned request.
REQ-026 RD: ram_en=1, ram_we=0; next state FIN.
REQ-027 FIN, load: resp_valid=1, resp_rdata = selected lane of ram_rdata, sign- or zero-extended per req_type[2]; next state IDLE.
REQ-028 FIN, sub-word store: ram_en=1, ram_we=1, ram_wdata = ram_rdata with the addressed byte (addr[1:0]) or half (addr[1]) replaced by the low bits of the captured wdata; resp_valid=1; next state IDLE.
REQ-029 WR: ram_en=1, ram_we=1, ram_wdata = captured wdata, resp_valid=1; next state IDLE.
REQ-030 ERR: no RAM strobe; resp_valid=1, resp_err=1, resp_rdata=0; next state IDLE.
REQ-031 Latency from the accept edge: resp_valid in cycle +2 for loads and sub-word stores, +1 for word stores and errors.
REQ-032 Minimum accept-to-accept spacing equals latency+1; there is no response backpressure.
REQ-033 ram_en, ram_we, ram_wdata, resp_* SHALL be decoded from registered state and registered request only, never from req_* inputs.
REQ-034 Byte lanes are little-endian: lane n = bits [8n+7:8n].

Reset
REQ-035 rst asserted at any time forces IDLE immediately; any in-flight access is abandoned with no write and no response.
REQ-036 Reset values: req_ready=1 after release, busy=0, resp_valid=0, resp_err=0, resp_rdata=0, ram_en=0, ram_we=0, ram_addr=0, ram_wdata=0, capture registers 0.

Structure
REQ-037 Shared package holds the req_type encodings, FSM state encodings and the DATA_W constant.
REQ-038 The pure-combinational lane logic (sub-word merge and extract/extend) lives in one sub-module, dmem_lane_align; the FSM and capture registers stay in dmem_access_ctrl.

Verification
REQ-039 RAM word 0x4 = 0x8899AABB; load byte signed at 0x11 -> resp_valid at +2 with resp_rdata = 0xFFFFFFAA, err=0.
REQ-040 Same RAM; load half unsigned at 0x12 -> resp_rdata = 0x00008899; load word at 0x10 -> 0x8899AABB.
REQ-041 Store byte wdata = 0x1234565C at 0x13 -> read at +1, then write at +2 to ram_addr 0x4 with ram_wdata = 0x5C99AABB, resp_valid at +2.
REQ-042 Word load at 0x02 and half store at 0x11 -> resp_valid=1 and resp_err=1 at +1, ram_en never asserted.
REQ-043 Assert rst during FIN of a byte store -> no ram_we pulse, no resp_valid, outputs at reset values, req_ready=1 after release.
REQ-044 Back-to-back: hold req_valid high with word store then byte load -> second accept occurs exactly 2 cycles after the first, responses in order.

Source files
------------

// File: rtl/dmem_access_ctrl_pkg.sv
// Shared definitions for the data-memory access controller.
//   - DMEM_DATA_W : the only supported data width (32)
//   - TYPE_*      : req_type encodings (bit 2 = zero-extend, bits 1:0 = size)
//   - state_e     : controller FSM states
//   - helpers     : access-size decode and misalignment check
package dmem_access_ctrl_pkg;

    localparam int unsigned DMEM_DATA_W = 32;

    localparam logic [2:0] TYPE_BYTE_S  = 3'b000;
    localparam logic [2:0] TYPE_HALF_S  = 3'b001;
    localparam logic [2:0] TYPE_WORD    = 3'b010;
    localparam logic [2:0] TYPE_WORD_X  = 3'b011;
    localparam logic [2:0] TYPE_BYTE_U  = 3'b100;
    localparam logic [2:0] TYPE_HALF_U  = 3'b101;

    typedef enum logic [2:0] {
        StIdle = 3'd0,
        StRd   = 3'd1,
        StFin  = 3'd2,
        StWr   = 3'd3,
        StErr  = 3'd4
    } state_e;

    // Bit 1 set means a full word (01x, and the unused 11x codes fall in here too).
    function automatic logic is_word(input logic [2:0] req_type);
        return req_type[1];
    endfunction

    function automatic logic is_half(input logic [2:0] req_type);
        return (req_type[1:0] == 2'b01);
    endfunction

    function automatic logic is_misaligned(input logic [2:0] req_type, input logic [1:0] addr_lo);
        if (is_word(req_type)) begin
            return (addr_lo != 2'b00);
        end else if (is_half(req_type)) begin
            return addr_lo[0];
        end
        return 1'b0;
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering for sub-word accesses on a little-endian 32-bit RAM.
//   req_type_i  : captured access type
//   addr_lo_i   : captured byte offset within the word
//   ram_rdata_i : word read from RAM
//   wdata_i     : captured right-aligned store data
//   merged_o    : RAM word with the addressed byte/half replaced (word: wdata_i)
//   load_o      : addressed lane, sign- or zero-extended (word: ram_rdata_i)
module dmem_lane_align
    import dmem_access_ctrl_pkg::*;
(
    input  logic [2:0]             req_type_i,
    input  logic [1:0]             addr_lo_i,
    input  logic [DMEM_DATA_W-1:0] ram_rdata_i,
    input  logic [DMEM_DATA_W-1:0] wdata_i,
    output logic [DMEM_DATA_W-1:0] merged_o,
    output logic [DMEM_DATA_W-1:0] load_o
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;
    logic        sext;

    always_comb begin
        byte_lane = ram_rdata_i[{addr_lo_i, 3'b000} +: 8];
        half_lane = ram_rdata_i[{addr_lo_i[1], 4'b0000} +: 16];
        sext      = ~req_type_i[2];

        if (is_word(req_type_i)) begin
            load_o = ram_rdata_i;
        end else if (is_half(req_type_i)) begin
            load_o = {{16{sext & half_lane[15]}}, half_lane};
        end else begin
            load_o = {{24{sext & byte_lane[7]}}, byte_lane};
        end
    end

    always_comb begin
        merged_o = ram_rdata_i;
        if (is_word(req_type_i)) begin
            merged_o = wdata_i;
        end else if (is_half(req_type_i)) begin
            merged_o[{addr_lo_i[1], 4'b0000} +: 16] = wdata_i[15:0];
        end else begin
            merged_o[{addr_lo_i, 3'b000} +: 8] = wdata_i[7:0];
        end
    end

endmodule

// File: rtl/dmem_access_ctrl.sv
// Data-memory access controller: accepts one load/store at a time, performs
// read-modify-write for sub-word stores, and reports misaligned accesses.
//   clk, rst                       : clock, asynchronous active-high reset
//   req_valid/req_ready            : request handshake (ready only when idle)
//   req_we, req_type, req_addr,
//   req_wdata                      : request fields, captured on accept
//   resp_valid, resp_rdata,
//   resp_err                       : one-cycle completion pulse with load data / error
//   ram_en, ram_we, ram_addr,
//   ram_wdata, ram_rdata           : synchronous RAM port (read data one cycle later)
//   busy                           : controller not idle
module dmem_access_ctrl
    import dmem_access_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = DMEM_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_type,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-3:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              busy
);

    state_e            state_q;
    logic              we_q;
    logic [2:0]        type_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;

    // Strobes are registered alongside the state transition that implies them.
    logic ram_en_q;
    logic ram_we_q;
    logic resp_valid_q;
    logic resp_err_q;

    logic [DATA_W-1:0] merged_word;
    logic [DATA_W-1:0] load_word;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            we_q         <= 1'b0;
            type_q       <= 3'b000;
            addr_q       <= '0;
            wdata_q      <= '0;
            ram_en_q     <= 1'b0;
            ram_we_q     <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
        end else begin
            ram_en_q     <= 1'b0;
            ram_we_q     <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (req_valid) begin
                        we_q    <= req_we;
                        type_q  <= req_type;
                        addr_q  <= req_addr;
                        wdata_q <= req_wdata;
                        if (is_misaligned(req_type, req_addr[1:0])) begin
                            state_q      <= StErr;
                            resp_valid_q <= 1'b1;
                            resp_err_q   <= 1'b1;
                        end else if (req_we && is_word(req_type)) begin
                            state_q      <= StWr;
                            ram_en_q     <= 1'b1;
                            ram_we_q     <= 1'b1;
                            resp_valid_q <= 1'b1;
                        end else begin
                            // Loads and sub-word stores both start with a read.
                            state_q  <= StRd;
                            ram_en_q <= 1'b1;
                        end
                    end
                end
                StRd: begin
                    state_q      <= StFin;
                    resp_valid_q <= 1'b1;
                    if (we_q) begin
                        ram_en_q <= 1'b1;
                        ram_we_q <= 1'b1;
                    end
                end
                StFin, StWr, StErr: state_q <= StIdle;
                default:            state_q <= StIdle;
            endcase
        end
    end

    dmem_lane_align u_lane_align (
        .req_type_i  (type_q),
        .addr_lo_i   (addr_q[1:0]),
        .ram_rdata_i (ram_rdata),
        .wdata_i     (wdata_q),
        .merged_o    (merged_word),
        .load_o      (load_word)
    );

    assign req_ready  = (state_q == StIdle);
    assign busy       = (state_q != StIdle);
    assign ram_en     = ram_en_q;
    assign ram_we     = ram_we_q;
    assign ram_addr   = addr_q[ADDR_W-1:2];
    assign resp_valid = resp_valid_q;
    assign resp_err   = resp_err_q;

    // Write data is driven only while writing so the bus idles at zero.
    assign ram_wdata  = !ram_we_q           ? '0 :
                        (state_q == StWr)   ? wdata_q : merged_word;

    assign resp_rdata = (state_q == StFin && !we_q) ? load_word : '0;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Self-checking bench for dmem_access_ctrl with a behavioural RAM and a
// byte-level reference model of loads, stores and alignment rules.
module tb_dmem_access_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_type;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        ram_en;
    logic        ram_we;
    logic [29:0] ram_addr;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata;
    logic        busy;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    dmem_access_ctrl #(
        .ADDR_W (32),
        .DATA_W (32)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_type   (req_type),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .ram_en     (ram_en),
        .ram_we     (ram_we),
        .ram_addr   (ram_addr),
        .ram_wdata  (ram_wdata),
        .ram_rdata  (ram_rdata),
        .busy       (busy)
    );

    // Behavioural synchronous RAM (16 words) plus event counters.
    logic [31:0] mem     [16];
    logic [31:0] ref_mem [16];
    int wr_count   = 0;
    int resp_count = 0;

    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we) begin
                mem[ram_addr[3:0]] <= ram_wdata;
                wr_count <= wr_count + 1;
            end else begin
                ram_rdata <= mem[ram_addr[3:0]];
            end
        end
        if (resp_valid) resp_count <= resp_count + 1;
    end

    // Per-access observations filled by do_access.
    int          rd_cyc;
    int          wr_cyc;
    logic [29:0] wr_addr;
    logic [31:0] wr_data;

    // ---------------- reference model ----------------
    function automatic int size_of(input logic [2:0] t);
        if (t[1]) return 4;
        if (t[0]) return 2;
        return 1;
    endfunction

    function automatic bit ref_misaligned(input logic [2:0] t, input logic [31:0] addr);
        return (int'(addr % 4) % size_of(t)) != 0;
    endfunction

    function automatic logic [31:0] ref_load(input logic [31:0] word, input logic [2:0] t,
                                             input logic [31:0] addr);
        int     n;
        int     sh;
        longint full;
        longint v;
        n = size_of(t);
        if (n == 4) return word;
        sh   = 8 * int'(addr % 4);
        full = longint'(1) << (8 * n);
        v    = (longint'(word) >> sh) % full;
        if (t[2] == 1'b0 && v >= full / 2) v = v - full;
        return v[31:0];
    endfunction

    function automatic logic [31:0] ref_store(input logic [31:0] word, input logic [2:0] t,
                                              input logic [31:0] addr, input logic [31:0] wd);
        int     n;
        int     sh;
        longint full;
        longint mask;
        longint res;
        n = size_of(t);
        if (n == 4) return wd;
        sh   = 8 * int'(addr % 4);
        full = longint'(1) << (8 * n);
        mask = (full - 1) << sh;
        res  = (longint'(word) & ~mask) | ((longint'(wd) % full) << sh);
        return res[31:0];
    endfunction

    // ---------------- transaction driver ----------------
    // Called at a negedge with the controller idle; returns at a negedge, idle again.
    task automatic do_access(input logic we, input logic [2:0] typ, input logic [31:0] addr,
                             input logic [31:0] wd, output logic [31:0] rd, output logic err,
                             output int lat, output bit saw_en);
        req_valid = 1'b1;
        req_we    = we;
        req_type  = typ;
        req_addr  = addr;
        req_wdata = wd;
        rd_cyc = -1; wr_cyc = -1; wr_addr = '0; wr_data = '0;
        rd = '0; err = 1'b0; lat = -1; saw_en = 1'b0;
        @(posedge clk);
        @(negedge clk);
        // Scramble inputs: the controller must work from its captured copy.
        req_valid = 1'b0;
        req_we    = 1'($urandom);
        req_type  = 3'($urandom);
        req_addr  = $urandom;
        req_wdata = $urandom;
        for (int k = 1; k <= 6; k++) begin
            if (ram_en) begin
                saw_en = 1'b1;
                if (ram_we) begin
                    wr_cyc = k; wr_addr = ram_addr; wr_data = ram_wdata;
                end else begin
                    rd_cyc = k;
                end
            end
            if (resp_valid) begin
                lat = k; rd = resp_rdata; err = resp_err;
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_type = 3'b000;
        req_addr = '0; req_wdata = '0;
        repeat (2) @(negedge clk);
        n_cmp++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_req_ready got=%b exp=1", req_ready); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
        n_cmp++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_resp_valid got=%b exp=0", resp_valid); end
        n_cmp++; if (resp_err !== 1'b0) begin n_fail++; $display("FAIL reset_resp_err got=%b exp=0", resp_err); end
        n_cmp++; if (resp_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_resp_rdata got=%h exp=0", resp_rdata); end
        n_cmp++; if (ram_en !== 1'b0) begin n_fail++; $display("FAIL reset_ram_en got=%b exp=0", ram_en); end
        n_cmp++; if (ram_we !== 1'b0) begin n_fail++; $display("FAIL reset_ram_we got=%b exp=0", ram_we); end
        n_cmp++; if (ram_addr !== 30'h0) begin n_fail++; $display("FAIL reset_ram_addr got=%h exp=0", ram_addr); end
        n_cmp++; if (ram_wdata !== 32'h0) begin n_fail++; $display("FAIL reset_ram_wdata got=%h exp=0", ram_wdata); end
        rst = 1'b0;
        @(negedge clk);
        n_cmp++; if (req_ready !== 1'b1 || busy !== 1'b0) begin
            n_fail++; $display("FAIL post_reset_idle got ready=%b busy=%b exp ready=1 busy=0", req_ready, busy);
        end
    endtask

    task automatic test_directed();
        logic [31:0] rd;
        logic        err;
        int          lat;
        bit          saw_en;
        mem[4] = 32'h8899AABB; ref_mem[4] = 32'h8899AABB;

        do_access(1'b0, 3'b000, 32'h11, 32'h0, rd, err, lat, saw_en);
        n_cmp++; if (lat !== 2) begin n_fail++; $display("FAIL lb_latency got=%0d exp=2", lat); end
        n_cmp++; if (rd !== 32'hFFFFFFAA) begin n_fail++; $display("FAIL lb_data got=%h exp=ffffffaa", rd); end
        n_cmp++; if (err !== 1'b0) begin n_fail++; $display("FAIL lb_err got=%b exp=0", err); end

        do_access(1'b0, 3'b101, 32'h12, 32'h0, rd, err, lat, saw_en);
        n_cmp++; if (rd !== 32'h00008899 || lat !== 2) begin
            n_fail++; $display("FAIL lhu got data=%h lat=%0d exp data=00008899 lat=2", rd, lat);
        end

        do_access(1'b0, 3'b010, 32'h10, 32'h0, rd, err, lat, saw_en);
        n_cmp++; if (rd !== 32'h8899AABB || lat !== 2) begin
            n_fail++; $display("FAIL lw got data=%h lat=%0d exp data=8899aabb lat=2", rd, lat);
        end

        do_access(1'b1, 3'b000, 32'h13, 32'h1234565C, rd, err, lat, saw_en);
        ref_mem[4] = 32'h5C99AABB;
        n_cmp++; if (rd_cyc !== 1) begin n_fail++; $display("FAIL sb_read_cycle got=%0d exp=1", rd_cyc); end
        n_cmp++; if (wr_cyc !== 2) begin n_fail++; $display("FAIL sb_write_cycle got=%0d exp=2", wr_cyc); end
        n_cmp++; if (wr_addr !== 30'h4) begin n_fail++; $display("FAIL sb_ram_addr got=%h exp=4", wr_addr); end
        n_cmp++; if (wr_data !== 32'h5C99AABB) begin n_fail++; $display("FAIL sb_ram_wdata got=%h exp=5c99aabb", wr_data); end
        n_cmp++; if (lat !== 2 || rd !== 32'h0 || err !== 1'b0) begin
            n_fail++; $display("FAIL sb_resp got lat=%0d data=%h err=%b exp lat=2 data=0 err=0", lat, rd, err);
        end
        n_cmp++; if (mem[4] !== 32'h5C99AABB) begin n_fail++; $display("FAIL sb_mem got=%h exp=5c99aabb", mem[4]); end

        do_access(1'b0, 3'b010, 32'h02, 32'h0, rd, err, lat, saw_en);
        n_cmp++; if (lat !== 1 || err !== 1'b1 || rd !== 32'h0 || saw_en !== 1'b0) begin
            n_fail++; $display("FAIL lw_misaligned got lat=%0d err=%b data=%h ram_en=%b exp lat=1 err=1 data=0 ram_en=0",
                               lat, err, rd, saw_en);
        end

        do_access(1'b1, 3'b001, 32'h11, 32'hCAFE, rd, err, lat, saw_en);
        n_cmp++; if (lat !== 1 || err !== 1'b1 || saw_en !== 1'b0) begin
            n_fail++; $display("FAIL sh_misaligned got lat=%0d err=%b ram_en=%b exp lat=1 err=1 ram_en=0",
                               lat, err, saw_en);
        end
    endtask

    task automatic test_reset_mid();
        int          wr0;
        int          rs0;
        logic [31:0] word0;
        word0 = mem[5];
        wr0 = wr_count;
        rs0 = resp_count;
        req_valid = 1'b1; req_we = 1'b1; req_type = 3'b100; req_addr = 32'h15; req_wdata = 32'h77;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        n_cmp++; if (ram_we !== 1'b1) begin n_fail++; $display("FAIL rst_mid_in_fin got ram_we=%b exp=1", ram_we); end
        rst = 1'b1;
        #1;
        n_cmp++; if (ram_en !== 1'b0 || ram_we !== 1'b0 || resp_valid !== 1'b0 || resp_err !== 1'b0) begin
            n_fail++; $display("FAIL rst_mid_strobes got en=%b we=%b rv=%b re=%b exp all 0",
                               ram_en, ram_we, resp_valid, resp_err);
        end
        n_cmp++; if (ram_addr !== 30'h0 || ram_wdata !== 32'h0 || resp_rdata !== 32'h0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL rst_mid_values got addr=%h wdata=%h rdata=%h busy=%b exp all 0",
                               ram_addr, ram_wdata, resp_rdata, busy);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_cmp++; if (wr_count !== wr0 || resp_count !== rs0) begin
            n_fail++; $display("FAIL rst_mid_no_effect got writes=%0d resps=%0d exp writes=%0d resps=%0d",
                               wr_count, resp_count, wr0, rs0);
        end
        n_cmp++; if (mem[5] !== word0) begin n_fail++; $display("FAIL rst_mid_mem got=%h exp=%h", mem[5], word0); end
        n_cmp++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL rst_mid_ready got=%b exp=1", req_ready); end
    endtask

    task automatic test_back_to_back();
        int          acc_c  [4];
        int          resp_c [4];
        logic [31:0] resp_d [4];
        int          n_acc;
        int          n_resp;
        logic [31:0] w;
        logic [31:0] exp_ld;
        n_acc = 0; n_resp = 0;
        w = $urandom;
        ref_mem[8] = w;
        exp_ld = ref_load(w, 3'b100, 32'h21);
        req_valid = 1'b1; req_we = 1'b1; req_type = 3'b010; req_addr = 32'h20; req_wdata = w;
        for (int c = 0; c < 10; c++) begin
            if (resp_valid && n_resp < 4) begin resp_c[n_resp] = c; resp_d[n_resp] = resp_rdata; n_resp++; end
            if (req_valid && req_ready && n_acc < 4) begin acc_c[n_acc] = c; n_acc++; end
            @(posedge clk);
            @(negedge clk);
            if (n_acc == 1) begin
                req_we = 1'b0; req_type = 3'b100; req_addr = 32'h21; req_wdata = $urandom;
            end else if (n_acc >= 2) begin
                req_valid = 1'b0;
            end
        end
        n_cmp++; if (n_acc !== 2 || n_resp !== 2) begin
            n_fail++; $display("FAIL b2b_counts got acc=%0d resp=%0d exp acc=2 resp=2", n_acc, n_resp);
        end else begin
            n_cmp++; if (acc_c[1] - acc_c[0] !== 2) begin
                n_fail++; $display("FAIL b2b_spacing got=%0d exp=2", acc_c[1] - acc_c[0]);
            end
            n_cmp++; if (resp_c[0] !== acc_c[0] + 1 || resp_c[1] !== acc_c[1] + 2) begin
                n_fail++; $display("FAIL b2b_resp_timing got=%0d,%0d exp=%0d,%0d",
                                   resp_c[0], resp_c[1], acc_c[0] + 1, acc_c[1] + 2);
            end
            n_cmp++; if (resp_d[1] !== exp_ld) begin
                n_fail++; $display("FAIL b2b_load_data got=%h exp=%h", resp_d[1], exp_ld);
            end
        end
    endtask

    task automatic test_random();
        logic [2:0]  types [6];
        logic [31:0] rd;
        logic        err;
        int          lat;
        bit          saw_en;
        logic        we;
        logic [2:0]  t;
        logic [31:0] a;
        logic [31:0] wd;
        int          idx;
        bit          mis;
        int          exp_lat;
        logic [31:0] exp_rd;
        types = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b100, 3'b101};
        for (int i = 0; i < 60; i++) begin
            we  = 1'($urandom);
            t   = types[$urandom_range(0, 5)];
            a   = $urandom_range(0, 63);
            wd  = $urandom;
            idx = int'(a / 4);
            mis = ref_misaligned(t, a);
            exp_lat = (mis || (we && size_of(t) == 4)) ? 1 : 2;
            exp_rd  = (mis || we) ? 32'h0 : ref_load(ref_mem[idx], t, a);
            if (we && !mis) ref_mem[idx] = ref_store(ref_mem[idx], t, a, wd);
            do_access(we, t, a, wd, rd, err, lat, saw_en);
            n_cmp++; if (lat !== exp_lat || err !== mis || rd !== exp_rd) begin
                n_fail++; $display("FAIL rand_%0d we=%b type=%b addr=%h got lat=%0d err=%b data=%h exp lat=%0d err=%b data=%h",
                                   i, we, t, a, lat, err, rd, exp_lat, mis, exp_rd);
            end
            if (mis) begin
                n_cmp++; if (saw_en !== 1'b0) begin
                    n_fail++; $display("FAIL rand_%0d_err_strobe got ram_en=%b exp=0", i, saw_en);
                end
            end
        end
        for (int j = 0; j < 16; j++) begin
            n_cmp++; if (mem[j] !== ref_mem[j]) begin
                n_fail++; $display("FAIL mem_word_%0d got=%h exp=%h", j, mem[j], ref_mem[j]);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) begin
            ref_mem[i] = $urandom;
            mem[i]     = ref_mem[i];
        end
        ram_rdata = '0;
        test_reset();
        test_directed();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
